// File: rtl/multiple_retire_packer.sv
// Packs single retired instructions into multi-slot retire bundles.
// A bundle closes when its last slot fills, on a trap or eret, or after an idle timeout.
package mure_pkg;
   parameter int unsigned INST_LEN  = 32;
   parameter int unsigned XLEN      = 32;
   parameter int unsigned CAUSE_LEN = 8;
endpackage

module multiple_retire_packer #(
   parameter int unsigned RETIRED_INSTR = 2,
   parameter int unsigned TIMEOUT       = 8
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic                                         in_valid_i,
   output logic                                         in_ready_o,
   input  logic [mure_pkg::INST_LEN-1:0]                inst_data_i,
   input  logic [mure_pkg::XLEN-1:0]                    pc_i,
   input  logic                                         exception_i,
   input  logic                                         interrupt_i,
   input  logic                                         eret_i,
   input  logic [mure_pkg::CAUSE_LEN-1:0]               cause_i,
   input  logic [mure_pkg::XLEN-1:0]                    tval_i,
   output logic                                         bundle_valid_o,
   input  logic                                         bundle_ready_i,
   output logic [RETIRED_INSTR-1:0]                     valids_o,
   output logic [RETIRED_INSTR*mure_pkg::INST_LEN-1:0]  uops_o,
   output logic [RETIRED_INSTR*mure_pkg::XLEN-1:0]      pcs_o,
   output logic                                         exception_o,
   output logic                                         interrupt_o,
   output logic                                         eret_o,
   output logic [mure_pkg::CAUSE_LEN-1:0]               cause_o,
   output logic [mure_pkg::XLEN-1:0]                    tval_o
);

   localparam int unsigned N  = RETIRED_INSTR;
   localparam int unsigned IL = mure_pkg::INST_LEN;
   localparam int unsigned XL = mure_pkg::XLEN;
   localparam int unsigned CL = mure_pkg::CAUSE_LEN;
   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   // Accumulator
   logic [CW-1:0]   acc_cnt_q,   acc_cnt_d;
   logic [N*IL-1:0] acc_uops_q,  acc_uops_d;
   logic [N*XL-1:0] acc_pcs_q,   acc_pcs_d;
   logic            acc_exc_q,   acc_exc_d;
   logic            acc_int_q,   acc_int_d;
   logic            acc_eret_q,  acc_eret_d;
   logic [CL-1:0]   acc_cause_q, acc_cause_d;
   logic [XL-1:0]   acc_tval_q,  acc_tval_d;
   logic            closed_q,    closed_d;
   logic [TW-1:0]   idle_q,      idle_d;

   // Output register
   logic            out_bv_q,     out_bv_d;
   logic [N-1:0]    out_valids_q, out_valids_d;
   logic [N*IL-1:0] out_uops_q,   out_uops_d;
   logic [N*XL-1:0] out_pcs_q,    out_pcs_d;
   logic            out_exc_q,    out_exc_d;
   logic            out_int_q,    out_int_d;
   logic            out_eret_q,   out_eret_d;
   logic [CL-1:0]   out_cause_q,  out_cause_d;
   logic [XL-1:0]   out_tval_q,   out_tval_d;

   // Accumulator merged with the current beat
   logic            accept, close_now, out_free, transfer;
   logic [CW-1:0]   m_cnt;
   logic [N*IL-1:0] m_uops;
   logic [N*XL-1:0] m_pcs;
   logic            m_exc, m_int, m_eret;
   logic [CL-1:0]   m_cause;
   logic [XL-1:0]   m_tval;

   always_comb begin
      acc_cnt_d    = acc_cnt_q;
      acc_uops_d   = acc_uops_q;
      acc_pcs_d    = acc_pcs_q;
      acc_exc_d    = acc_exc_q;
      acc_int_d    = acc_int_q;
      acc_eret_d   = acc_eret_q;
      acc_cause_d  = acc_cause_q;
      acc_tval_d   = acc_tval_q;
      closed_d     = closed_q;
      idle_d       = idle_q;
      out_bv_d     = out_bv_q;
      out_valids_d = out_valids_q;
      out_uops_d   = out_uops_q;
      out_pcs_d    = out_pcs_q;
      out_exc_d    = out_exc_q;
      out_int_d    = out_int_q;
      out_eret_d   = out_eret_q;
      out_cause_d  = out_cause_q;
      out_tval_d   = out_tval_q;

      accept  = in_valid_i && !closed_q;
      m_cnt   = acc_cnt_q;
      m_uops  = acc_uops_q;
      m_pcs   = acc_pcs_q;
      m_exc   = acc_exc_q;
      m_int   = acc_int_q;
      m_eret  = acc_eret_q;
      m_cause = acc_cause_q;
      m_tval  = acc_tval_q;

      if (accept) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (acc_cnt_q == CW'(i)) begin
               m_uops[i*IL +: IL] = inst_data_i;
               m_pcs[i*XL +: XL]  = pc_i;
            end
         end
         m_cnt  = acc_cnt_q + CW'(1);
         m_exc  = exception_i;
         m_int  = interrupt_i;
         m_eret = eret_i;
         if (exception_i || interrupt_i) begin
            m_cause = cause_i;
            m_tval  = tval_i;
         end else begin
            m_cause = '0;
            m_tval  = '0;
         end
      end

      close_now = (accept && ((acc_cnt_q == CW'(N - 1)) || exception_i || interrupt_i || eret_i))
               || (!accept && !closed_q && (acc_cnt_q != '0) && (idle_q == TW'(TIMEOUT - 1)));
      out_free  = !out_bv_q || bundle_ready_i;
      transfer  = (close_now || closed_q) && out_free;

      if (out_bv_q && bundle_ready_i) out_bv_d = 1'b0;

      if (transfer) begin
         out_bv_d    = 1'b1;
         for (int unsigned i = 0; i < N; i++) out_valids_d[i] = (CW'(i) < m_cnt);
         out_uops_d  = m_uops;
         out_pcs_d   = m_pcs;
         out_exc_d   = m_exc;
         out_int_d   = m_int;
         out_eret_d  = m_eret;
         out_cause_d = m_cause;
         out_tval_d  = m_tval;
         acc_cnt_d   = '0;
         acc_uops_d  = '0;
         acc_pcs_d   = '0;
         acc_exc_d   = 1'b0;
         acc_int_d   = 1'b0;
         acc_eret_d  = 1'b0;
         acc_cause_d = '0;
         acc_tval_d  = '0;
         closed_d    = 1'b0;
         idle_d      = '0;
      end else begin
         acc_cnt_d   = m_cnt;
         acc_uops_d  = m_uops;
         acc_pcs_d   = m_pcs;
         acc_exc_d   = m_exc;
         acc_int_d   = m_int;
         acc_eret_d  = m_eret;
         acc_cause_d = m_cause;
         acc_tval_d  = m_tval;
         closed_d    = closed_q || close_now;
         // Idle count runs only while a partial bundle waits without new beats
         if (accept || close_now || closed_q || (m_cnt == '0)) idle_d = '0;
         else                                                  idle_d = idle_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_cnt_q    <= '0;
         acc_uops_q   <= '0;
         acc_pcs_q    <= '0;
         acc_exc_q    <= 1'b0;
         acc_int_q    <= 1'b0;
         acc_eret_q   <= 1'b0;
         acc_cause_q  <= '0;
         acc_tval_q   <= '0;
         closed_q     <= 1'b0;
         idle_q       <= '0;
         out_bv_q     <= 1'b0;
         out_valids_q <= '0;
         out_uops_q   <= '0;
         out_pcs_q    <= '0;
         out_exc_q    <= 1'b0;
         out_int_q    <= 1'b0;
         out_eret_q   <= 1'b0;
         out_cause_q  <= '0;
         out_tval_q   <= '0;
      end else begin
         acc_cnt_q    <= acc_cnt_d;
         acc_uops_q   <= acc_uops_d;
         acc_pcs_q    <= acc_pcs_d;
         acc_exc_q    <= acc_exc_d;
         acc_int_q    <= acc_int_d;
         acc_eret_q   <= acc_eret_d;
         acc_cause_q  <= acc_cause_d;
         acc_tval_q   <= acc_tval_d;
         closed_q     <= closed_d;
         idle_q       <= idle_d;
         out_bv_q     <= out_bv_d;
         out_valids_q <= out_valids_d;
         out_uops_q   <= out_uops_d;
         out_pcs_q    <= out_pcs_d;
         out_exc_q    <= out_exc_d;
         out_int_q    <= out_int_d;
         out_eret_q   <= out_eret_d;
         out_cause_q  <= out_cause_d;
         out_tval_q   <= out_tval_d;
      end
   end

   assign in_ready_o     = !closed_q;
   assign bundle_valid_o = out_bv_q;
   assign valids_o       = out_valids_q;
   assign uops_o         = out_uops_q;
   assign pcs_o          = out_pcs_q;
   assign exception_o    = out_exc_q;
   assign interrupt_o    = out_int_q;
   assign eret_o         = out_eret_q;
   assign cause_o        = out_cause_q;
   assign tval_o         = out_tval_q;

endmodule

// File: tb/tb_multiple_retire_packer.sv
// Directed bench for multiple_retire_packer (2 slots, timeout 4) with an expected-bundle queue.
module tb_multiple_retire_packer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] inst_data_i;
   logic [31:0] pc_i;
   logic        exception_i, interrupt_i, eret_i;
   logic [7:0]  cause_i;
   logic [31:0] tval_i;
   logic        bundle_valid_o;
   logic        bundle_ready_i;
   logic [1:0]  valids_o;
   logic [63:0] uops_o;
   logic [63:0] pcs_o;
   logic        exception_o, interrupt_o, eret_o;
   logic [7:0]  cause_o;
   logic [31:0] tval_o;

   typedef struct {
      logic [1:0]  valids;
      logic [63:0] uops;
      logic [63:0] pcs;
      logic        exc;
      logic        intr;
      logic        eret;
      logic [7:0]  cause;
      logic [31:0] tval;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   multiple_retire_packer #(.RETIRED_INSTR(2), .TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .inst_data_i(inst_data_i), .pc_i(pc_i),
      .exception_i(exception_i), .interrupt_i(interrupt_i), .eret_i(eret_i),
      .cause_i(cause_i), .tval_i(tval_i),
      .bundle_valid_o(bundle_valid_o), .bundle_ready_i(bundle_ready_i),
      .valids_o(valids_o), .uops_o(uops_o), .pcs_o(pcs_o),
      .exception_o(exception_o), .interrupt_o(interrupt_o), .eret_o(eret_o),
      .cause_o(cause_o), .tval_o(tval_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] v, input logic [63:0] u, input logic [63:0] p,
                       input logic e, input logic i, input logic r,
                       input logic [7:0] c, input logic [31:0] t);
      exp_t x;
      x.valids = v; x.uops = u; x.pcs = p;
      x.exc = e; x.intr = i; x.eret = r; x.cause = c; x.tval = t;
      sb.push_back(x);
   endtask

   // Pop and compare on each accepted bundle, then advance one clock
   task automatic tick();
      exp_t x;
      @(negedge clk_i);
      if (bundle_valid_o && bundle_ready_i) begin
         if (sb.size() == 0) begin
            check("unexpected_bundle", 64'(bundle_valid_o), 64'd0);
         end else begin
            x = sb.pop_front();
            check("sb_valids", 64'(valids_o), 64'(x.valids));
            check("sb_uops", uops_o, x.uops);
            check("sb_pcs", pcs_o, x.pcs);
            check("sb_exc", 64'(exception_o), 64'(x.exc));
            check("sb_int", 64'(interrupt_o), 64'(x.intr));
            check("sb_eret", 64'(eret_o), 64'(x.eret));
            check("sb_cause", 64'(cause_o), 64'(x.cause));
            check("sb_tval", 64'(tval_o), 64'(x.tval));
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input logic [31:0] op, input logic [31:0] pc,
                       input logic e, input logic i, input logic r,
                       input logic [7:0] c, input logic [31:0] t);
      in_valid_i = 1'b1; inst_data_i = op; pc_i = pc;
      exception_i = e; interrupt_i = i; eret_i = r; cause_i = c; tval_i = t;
   endtask

   task automatic no_beat();
      in_valid_i = 1'b0; inst_data_i = '0; pc_i = '0;
      exception_i = 1'b0; interrupt_i = 1'b0; eret_i = 1'b0; cause_i = '0; tval_i = '0;
   endtask

   initial begin
      int n;
      rst_i = 1'b1; bundle_ready_i = 1'b1;
      no_beat();
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Reset state
      check("rst_bv", 64'(bundle_valid_o), 64'd0);
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      check("rst_valids", 64'(valids_o), 64'd0);
      check("rst_uops", uops_o, 64'd0);
      check("rst_pcs", pcs_o, 64'd0);
      check("rst_flags", 64'({exception_o, interrupt_o, eret_o}), 64'd0);
      check("rst_cause", 64'(cause_o), 64'd0);
      check("rst_tval", 64'(tval_o), 64'd0);

      // Two beats fill a bundle
      push(2'b11, 64'h00000033_00000013, 64'h00000104_00000100, 0, 0, 0, 8'd0, 32'd0);
      beat(32'h13, 32'h100, 0, 0, 0, 8'd0, 32'd0); tick();
      beat(32'h33, 32'h104, 0, 0, 0, 8'd0, 32'd0); tick();
      no_beat();
      check("full_latency_bv", 64'(bundle_valid_o), 64'd1);
      tick(); tick();

      // Exception closes a one-slot bundle
      push(2'b01, 64'h00000000_00000013, 64'h00000000_00000100, 1, 0, 0, 8'd2, 32'hDEAD);
      beat(32'h13, 32'h100, 1, 0, 0, 8'd2, 32'hDEAD); tick();
      no_beat();
      check("exc_latency_bv", 64'(bundle_valid_o), 64'd1);
      tick();

      // Eret in slot 1: cause/tval must read zero
      push(2'b11, 64'h00000073_00000017, 64'h00000124_00000120, 0, 0, 1, 8'd0, 32'd0);
      beat(32'h17, 32'h120, 0, 0, 0, 8'd0, 32'd0); tick();
      beat(32'h73, 32'h124, 0, 0, 1, 8'd5, 32'h55); tick();
      no_beat(); tick();

      // Exception and interrupt together
      push(2'b01, 64'h00000000_00000023, 64'h00000000_00000140, 1, 1, 0, 8'd9, 32'hBEEF);
      beat(32'h23, 32'h140, 1, 1, 0, 8'd9, 32'hBEEF); tick();
      no_beat(); tick();

      // Idle timeout flushes a partial bundle 4 cycles after acceptance
      push(2'b01, 64'h00000000_00000093, 64'h00000000_00000200, 0, 0, 0, 8'd0, 32'd0);
      beat(32'h93, 32'h200, 0, 0, 0, 8'd0, 32'd0); tick();
      no_beat();
      n = 0;
      while (!bundle_valid_o && n < 10) begin tick(); n++; end
      check("timeout_cycles", 64'(n), 64'd4);
      tick(); tick();

      // Backpressure: first bundle held, second closes and stalls input
      bundle_ready_i = 1'b0;
      push(2'b11, 64'h00000002_00000001, 64'h00000304_00000300, 0, 0, 0, 8'd0, 32'd0);
      push(2'b11, 64'h00000004_00000003, 64'h0000030C_00000308, 0, 0, 0, 8'd0, 32'd0);
      beat(32'h1, 32'h300, 0, 0, 0, 8'd0, 32'd0); tick();
      beat(32'h2, 32'h304, 0, 0, 0, 8'd0, 32'd0); tick();
      beat(32'h3, 32'h308, 0, 0, 0, 8'd0, 32'd0); tick();
      check("bp_hold_uops_c", uops_o, 64'h00000002_00000001);
      check("bp_ready_c", 64'(in_ready_o), 64'd1);
      beat(32'h4, 32'h30C, 0, 0, 0, 8'd0, 32'd0); tick();
      no_beat();
      check("bp_closed_ready", 64'(in_ready_o), 64'd0);
      check("bp_hold_bv", 64'(bundle_valid_o), 64'd1);
      check("bp_hold_uops_d", uops_o, 64'h00000002_00000001);
      tick();
      check("bp_closed_ready2", 64'(in_ready_o), 64'd0);
      check("bp_hold_pcs", pcs_o, 64'h00000304_00000300);
      bundle_ready_i = 1'b1;
      tick();
      check("bp_second_bv", 64'(bundle_valid_o), 64'd1);
      check("bp_second_uops", uops_o, 64'h00000004_00000003);
      check("bp_ready_back", 64'(in_ready_o), 64'd1);
      tick();
      check("bp_drained_bv", 64'(bundle_valid_o), 64'd0);

      // Back-to-back full bundles: input never stalls
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 1)
            push(2'b11, {32'(32'h40 + i), 32'(32'h40 + i - 1)},
                 {32'(32'h400 + 4 * i), 32'(32'h400 + 4 * (i - 1))}, 0, 0, 0, 8'd0, 32'd0);
         beat(32'(32'h40 + i), 32'(32'h400 + 4 * i), 0, 0, 0, 8'd0, 32'd0);
         tick();
         check("b2b_ready", 64'(in_ready_o), 64'd1);
         check("b2b_bv", 64'(bundle_valid_o), 64'(i % 2));
      end
      // Eret on every beat: bundle_valid_o stays high continuously
      for (int i = 0; i < 4; i++) begin
         push(2'b01, {32'd0, 32'(32'h60 + i)}, {32'd0, 32'(32'h600 + 4 * i)}, 0, 0, 1, 8'd0, 32'd0);
         beat(32'(32'h60 + i), 32'(32'h600 + 4 * i), 0, 0, 1, 8'd0, 32'd0);
         tick();
         check("b2b_eret_bv", 64'(bundle_valid_o), 64'd1);
         check("b2b_eret_ready", 64'(in_ready_o), 64'd1);
      end
      no_beat(); tick(); tick();

      // Reset with one bundle pending and one beat buffered
      bundle_ready_i = 1'b0;
      beat(32'h71, 32'h700, 0, 0, 0, 8'd0, 32'd0); tick();
      beat(32'h72, 32'h704, 0, 0, 0, 8'd0, 32'd0); tick();
      beat(32'h73, 32'h708, 0, 0, 0, 8'd0, 32'd0); tick();
      no_beat();
      check("pre_rst_bv", 64'(bundle_valid_o), 64'd1);
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      check("mid_rst_bv", 64'(bundle_valid_o), 64'd0);
      check("mid_rst_ready", 64'(in_ready_o), 64'd1);
      check("mid_rst_valids", 64'(valids_o), 64'd0);
      bundle_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("post_rst_no_bundle", 64'(bundle_valid_o), 64'd0);
      end

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
